sdram_bank_controller: RTL and testbench

Sequences a single SDRAM bank on behalf of one requester. The block accepts word read/write requests and keeps at most one row open in the row buffer (open-page policy). It issues the precharge, activate and column read/write strobes with programmable tRP/tRCD/CL delays, and returns read data or a write acknowledge. It sits between the bus interface and the bank's row-buffer read/write datapath.

---
 rtl/sdram_bank_controller.sv | 110 +++++++++++
 tb/tb_sdram_bank_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bank_controller.sv
// sdram_bank_controller: open-page single-bank SDRAM sequencer with programmable tRP/tRCD/CL delays
module sdram_bank_controller #(
    parameter int ROW_ADDR_SIZE = 12,
    parameter int COL_ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32,
    parameter int T_RP = 2,
    parameter int T_RCD = 2,
    parameter int T_CL = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ReqValid,
    output logic ReqReady,
    input  logic ReqWrite,
    input  logic [ROW_ADDR_SIZE+COL_ADDR_SIZE-1:0] ReqAddress,
    input  logic [DATA_SIZE-1:0] ReqData,
    output logic RespValid,
    output logic [DATA_SIZE-1:0] RespData,
    output logic [ROW_ADDR_SIZE-1:0] RowAddress,
    output logic ActivateEn,
    output logic PrechargeEn,
    output logic [COL_ADDR_SIZE-1:0] ColAddress,
    output logic WE,
    output logic RE,
    output logic [DATA_SIZE-1:0] Datain,
    input  logic [DATA_SIZE-1:0] BankDataOut
);
    typedef enum logic [2:0] {IDLE, PRECHARGE, ACTIVATE, ACCESS, READ_WAIT} stateT;
    localparam logic [3:0] RP_LAST = 4'(T_RP - 1);
    localparam logic [3:0] RCD_LAST = 4'(T_RCD - 1);
    localparam logic [3:0] CL_LAST = 4'(T_CL - 1);
    stateT state, nextState;
    logic [3:0] count;
    logic rowOpen, capWrite, respPending, handshake, hit, lastCycle;
    logic [ROW_ADDR_SIZE-1:0] reqRow, openRow, capRow, heldRow;
    logic [COL_ADDR_SIZE-1:0] capCol, heldCol;
    logic [DATA_SIZE-1:0] capData, heldData;
    assign reqRow = ReqAddress[ROW_ADDR_SIZE+COL_ADDR_SIZE-1:COL_ADDR_SIZE];
    assign handshake = ReqValid && ReqReady;
    assign hit = rowOpen && reqRow == openRow;
    assign lastCycle = count == 4'd0;

    // State register
    always_ff @(posedge Clk) state <= Reset ? IDLE : nextState;

    // Next-state: timed phases leave when the delay counter reaches zero
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (handshake) nextState = hit ? ACCESS : rowOpen ? PRECHARGE : ACTIVATE;
            PRECHARGE: if (lastCycle) nextState = ACTIVATE;
            ACTIVATE:  if (lastCycle) nextState = ACCESS;
            ACCESS:    nextState = capWrite ? IDLE : READ_WAIT;
            READ_WAIT: if (lastCycle) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Outputs: strobes fire on the first cycle of their phase; buses hold their last driven value
    always_comb begin
        ReqReady = !Reset && state == IDLE;
        PrechargeEn = !Reset && state == PRECHARGE && count == RP_LAST;
        ActivateEn = !Reset && state == ACTIVATE && count == RCD_LAST;
        WE = !Reset && state == ACCESS && capWrite;
        RE = !Reset && state == ACCESS && !capWrite;
        RespValid = !Reset && respPending;
        RowAddress = Reset ? '0 : ActivateEn ? capRow : heldRow;
        ColAddress = Reset ? '0 : (WE || RE) ? capCol : heldCol;
        Datain = Reset ? '0 : WE ? capData : heldData;
    end

    // Datapath: delay counter, open-row tracking, request capture and response registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
            rowOpen <= 1'b0;
            openRow <= '0;
            respPending <= 1'b0;
            RespData <= '0;
            heldRow <= '0;
            heldCol <= '0;
            heldData <= '0;
            capWrite <= 1'b0;
            capRow <= '0;
            capCol <= '0;
            capData <= '0;
        end else begin
            count <= (nextState == PRECHARGE && state != PRECHARGE) ? RP_LAST :
                     (nextState == ACTIVATE && state != ACTIVATE) ? RCD_LAST :
                     (nextState == READ_WAIT && state != READ_WAIT) ? CL_LAST :
                     lastCycle ? 4'd0 : count - 4'd1;
            respPending <= (state == ACCESS && capWrite) || (state == READ_WAIT && lastCycle);
            if (state == READ_WAIT && lastCycle) RespData <= BankDataOut;
            heldRow <= RowAddress;
            heldCol <= ColAddress;
            heldData <= Datain;
            if (handshake) begin
                capWrite <= ReqWrite;
                capRow <= reqRow;
                capCol <= ReqAddress[COL_ADDR_SIZE-1:0];
                capData <= ReqData;
            end
            if (nextState == PRECHARGE) rowOpen <= 1'b0;
            else if (nextState == ACTIVATE && state != ACTIVATE) begin
                rowOpen <= 1'b1;
                openRow <= handshake ? reqRow : capRow;
            end
        end
    end
endmodule

// File: tb/tb_sdram_bank_controller.sv
// tb_sdram_bank_controller: directed and randomized checks of sdram_bank_controller against an event-schedule model
module tb_sdram_bank_controller;
    localparam int RW = 12, CW = 8, DW = 32, AW = RW + CW;
    localparam int TRP = 2, TRCD = 2, TCL = 2;
    localparam int MAXC = 16384;

    logic Clk = 1'b0;
    logic Reset = 1'b1, ReqValid = 1'b0, ReqWrite = 1'b0;
    logic [AW-1:0] ReqAddress = '0;
    logic [DW-1:0] ReqData = '0, BankDataOut = '0;
    logic ReqReady, RespValid, ActivateEn, PrechargeEn, WE, RE;
    logic [DW-1:0] RespData, Datain;
    logic [RW-1:0] RowAddress;
    logic [CW-1:0] ColAddress;

    logic Reset1 = 1'b1, ReqValid1 = 1'b0, ReqWrite1 = 1'b0;
    logic [AW-1:0] ReqAddress1 = '0;
    logic [DW-1:0] ReqData1 = '0, BankDataOut1 = 32'hCAFEF00D;
    logic ReqReady1, RespValid1, ActivateEn1, PrechargeEn1, WE1, RE1;
    logic [DW-1:0] RespData1, Datain1;
    logic [RW-1:0] RowAddress1;
    logic [CW-1:0] ColAddress1;

    int checks = 0, errors = 0, off = 0;
    bit randData = 1'b0;
    logic [DW-1:0] fixedData = '0;

    sdram_bank_controller dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddress(ReqAddress), .ReqData(ReqData), .RespValid(RespValid), .RespData(RespData),
        .RowAddress(RowAddress), .ActivateEn(ActivateEn), .PrechargeEn(PrechargeEn),
        .ColAddress(ColAddress), .WE(WE), .RE(RE), .Datain(Datain), .BankDataOut(BankDataOut)
    );

    sdram_bank_controller #(.T_RP(1), .T_RCD(1), .T_CL(1)) dut1 (
        .Clk(Clk), .Reset(Reset1), .ReqValid(ReqValid1), .ReqReady(ReqReady1), .ReqWrite(ReqWrite1),
        .ReqAddress(ReqAddress1), .ReqData(ReqData1), .RespValid(RespValid1), .RespData(RespData1),
        .RowAddress(RowAddress1), .ActivateEn(ActivateEn1), .PrechargeEn(PrechargeEn1),
        .ColAddress(ColAddress1), .WE(WE1), .RE(RE1), .Datain(Datain1), .BankDataOut(BankDataOut1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40) $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Schedule model: each accepted request books its strobes and response at absolute cycles
    bit expPre[MAXC], expAct[MAXC], expWe[MAXC], expRe[MAXC], expRv[MAXC], capAt[MAXC];
    logic [RW-1:0] evRow[MAXC];
    logic [CW-1:0] evCol[MAXC];
    logic [DW-1:0] evData[MAXC];
    int cyc = 0, readyCycle = 0, rvSeen = 0;
    bit mRowOpen = 1'b0;
    logic [RW-1:0] mOpenRow = '0, hRow = '0;
    logic [CW-1:0] hCol = '0;
    logic [DW-1:0] hData = '0, mResp = '0;

    // Compare DUT outputs with the model in the middle of every cycle, then advance the model
    always @(negedge Clk) begin
        int c, t;
        logic [RW-1:0] row;
        c = cyc;
        cyc++;
        if (c + 40 >= MAXC) begin
            $display("FAIL model_overflow cycle=%0d", c);
            $fatal(1);
        end
        if (RespValid) rvSeen++;
        chk("strobe_overlap", 64'($countones({PrechargeEn, ActivateEn, WE, RE}) > 1), 64'd0);
        if (Reset) begin
            chk("rst_ReqReady", 64'(ReqReady), 64'd0);
            chk("rst_RespValid", 64'(RespValid), 64'd0);
            chk("rst_strobes", 64'({PrechargeEn, ActivateEn, WE, RE}), 64'd0);
            for (int i = c; i < c + 40; i++) begin
                expPre[i] = 0; expAct[i] = 0; expWe[i] = 0; expRe[i] = 0; expRv[i] = 0; capAt[i] = 0;
            end
            mRowOpen = 0; hRow = '0; hCol = '0; hData = '0; mResp = '0;
            readyCycle = c + 1;
        end else begin
            if (expAct[c]) hRow = evRow[c];
            if (expWe[c] || expRe[c]) hCol = evCol[c];
            if (expWe[c]) hData = evData[c];
            chk("ReqReady", 64'(ReqReady), 64'(c >= readyCycle));
            chk("PrechargeEn", 64'(PrechargeEn), 64'(expPre[c]));
            chk("ActivateEn", 64'(ActivateEn), 64'(expAct[c]));
            chk("WE", 64'(WE), 64'(expWe[c]));
            chk("RE", 64'(RE), 64'(expRe[c]));
            chk("RespValid", 64'(RespValid), 64'(expRv[c]));
            chk("RowAddress", 64'(RowAddress), 64'(hRow));
            chk("ColAddress", 64'(ColAddress), 64'(hCol));
            chk("Datain", 64'(Datain), 64'(hData));
            chk("RespData", 64'(RespData), 64'(mResp));
            if (capAt[c]) mResp = BankDataOut;
            if (ReqValid && c >= readyCycle) begin
                row = ReqAddress[AW-1:CW];
                t = c + 1;
                if (!(mRowOpen && row == mOpenRow)) begin
                    if (mRowOpen) begin expPre[t] = 1; t += TRP; end
                    expAct[t] = 1; evRow[t] = row; t += TRCD;
                    mRowOpen = 1; mOpenRow = row;
                end
                evCol[t] = ReqAddress[CW-1:0];
                if (ReqWrite) begin
                    expWe[t] = 1; evData[t] = ReqData; expRv[t+1] = 1; readyCycle = t + 1;
                end else begin
                    expRe[t] = 1; capAt[t+TCL] = 1; expRv[t+TCL+1] = 1; readyCycle = t + TCL + 1;
                end
            end
        end
    end

    // Row-buffer read data: fixed in directed phases, random per cycle afterwards
    initial forever begin
        @(posedge Clk); #1;
        BankDataOut = randData ? $urandom : fixedData;
    end

    task automatic nextCyc();
        @(posedge Clk); #1;
    endtask

    task automatic sendReq(input bit sel, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
        int i;
        nextCyc();
        if (sel) begin ReqValid1 = 1; ReqWrite1 = w; ReqAddress1 = a; ReqData1 = d; end
        else begin ReqValid = 1; ReqWrite = w; ReqAddress = a; ReqData = d; end
        for (i = 0; i < 200; i++) begin
            #2;
            if (sel ? ReqReady1 : ReqReady) break;
            nextCyc();
        end
        if (i == 200) begin
            checks++; errors++;
            $display("FAIL handshake_timeout t=%0t actual=no_ready required=ready", $time);
        end
        nextCyc();
        if (!hold) begin
            if (sel) ReqValid1 = 0;
            else ReqValid = 0;
        end
        off = 1;
    endtask

    task automatic goTo(input int n);
        while (off < n) begin @(posedge Clk); #1; off++; end
        #2;
    endtask

    initial begin
        int rvBefore;
        fixedData = 32'hDEADBEEF;
        repeat (3) nextCyc();
        #2;
        chk("reset_ReqReady", 64'(ReqReady), 64'd0);
        chk("reset_RespValid", 64'(RespValid), 64'd0);
        chk("reset_RowAddress", 64'(RowAddress), 64'd0);
        Reset = 0;
        // closed-row read
        sendReq(0, 0, 20'h00105, '0, 0);
        goTo(1); chk("miss_act", 64'(ActivateEn), 64'd1); chk("miss_row", 64'(RowAddress), 64'd1);
        goTo(3); chk("miss_re", 64'(RE), 64'd1); chk("miss_col", 64'(ColAddress), 64'h05);
        goTo(5); chk("miss_rv_early", 64'(RespValid), 64'd0);
        goTo(6); chk("miss_rv", 64'(RespValid), 64'd1); chk("miss_data", 64'(RespData), 64'hDEADBEEF);
        // write hit
        sendReq(0, 1, 20'h00108, 32'h12345678, 0);
        goTo(1); chk("hit_we", 64'(WE), 64'd1); chk("hit_datain", 64'(Datain), 64'h12345678);
        chk("hit_no_act", 64'(ActivateEn | PrechargeEn), 64'd0); chk("hit_col", 64'(ColAddress), 64'h08);
        goTo(2); chk("hit_rv", 64'(RespValid), 64'd1); chk("hit_ready", 64'(ReqReady), 64'd1);
        // conflict read
        sendReq(0, 0, 20'h00200, '0, 0);
        goTo(1); chk("conf_pre", 64'(PrechargeEn), 64'd1);
        goTo(2); chk("conf_pre_once", 64'(PrechargeEn), 64'd0);
        goTo(3); chk("conf_act", 64'(ActivateEn), 64'd1); chk("conf_row", 64'(RowAddress), 64'd2);
        goTo(5); chk("conf_re", 64'(RE), 64'd1); chk("conf_col", 64'(ColAddress), 64'h00);
        goTo(8); chk("conf_rv", 64'(RespValid), 64'd1);
        // reset during ACTIVATE
        sendReq(0, 0, 20'h00300, '0, 0);
        goTo(3); chk("rst_mid_act", 64'(ActivateEn), 64'd1);
        Reset = 1;
        goTo(4);
        chk("rst_mid_act0", 64'(ActivateEn), 64'd0); chk("rst_mid_row", 64'(RowAddress), 64'd0);
        chk("rst_mid_col", 64'(ColAddress), 64'd0); chk("rst_mid_din", 64'(Datain), 64'd0);
        chk("rst_mid_rdata", 64'(RespData), 64'd0); chk("rst_mid_ready", 64'(ReqReady), 64'd0);
        Reset = 0;
        for (int n = 5; n <= 10; n++) begin goTo(n); chk("rst_no_resp", 64'(RespValid), 64'd0); end
        sendReq(0, 0, 20'h00300, '0, 0);
        goTo(1); chk("post_rst_act", 64'(ActivateEn), 64'd1); chk("post_rst_row", 64'(RowAddress), 64'd3);
        chk("post_rst_no_pre", 64'(PrechargeEn), 64'd0);
        goTo(6); chk("post_rst_rv", 64'(RespValid), 64'd1);
        goTo(7);
        // ReqValid held high across alternating hits
        rvBefore = rvSeen;
        sendReq(0, 1, 20'h00310, 32'hA5A5A5A5, 1);
        sendReq(0, 0, 20'h00314, '0, 1);
        sendReq(0, 1, 20'h00318, 32'h5A5A5A5A, 1);
        sendReq(0, 0, 20'h00318, '0, 0);
        goTo(8); chk("hold_resp_count", 64'(rvSeen - rvBefore), 64'd4);
        // randomized traffic with occasional mid-operation reset
        randData = 1;
        for (int r = 0; r < 250; r++) begin
            repeat ($urandom_range(0, 2)) nextCyc();
            sendReq(0, 1'($urandom_range(0, 1)), {12'($urandom_range(0, 3)), 8'($urandom)}, $urandom,
                    $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, 6)) nextCyc();
                Reset = 1;
                nextCyc();
                Reset = 0;
            end
        end
        ReqValid = 0;
        repeat (15) nextCyc();
        // minimum-latency instance: closed read, then conflict read
        Reset1 = 0;
        sendReq(1, 0, 20'h00105, '0, 0);
        goTo(1); chk("t1_act", 64'(ActivateEn1), 64'd1);
        goTo(4); chk("t1_miss_rv", 64'(RespValid1), 64'd1); chk("t1_miss_data", 64'(RespData1), 64'hCAFEF00D);
        sendReq(1, 0, 20'h00200, '0, 0);
        goTo(1); chk("t1_pre", 64'(PrechargeEn1), 64'd1); chk("t1_pre_noact", 64'(ActivateEn1), 64'd0);
        goTo(2); chk("t1_act2", 64'(ActivateEn1), 64'd1); chk("t1_row", 64'(RowAddress1), 64'd2);
        goTo(3); chk("t1_re", 64'(RE1), 64'd1); chk("t1_col", 64'(ColAddress1), 64'd0);
        goTo(4); chk("t1_rv_early", 64'(RespValid1), 64'd0);
        goTo(5); chk("t1_rv", 64'(RespValid1), 64'd1); chk("t1_ready", 64'(ReqReady1), 64'd1);
        repeat (5) nextCyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout t=%0t actual=running required=finished", $time);
        $fatal(1);
    end
endmodule
